// File: rtl/jesd204_tx_gearbox_ctrl_pkg.sv
// Shared definitions for the JESD204 TX gearbox release controller.
package jesd204_tx_gearbox_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LMFC = 2'd1,
    ST_DELAY     = 2'd2,
    ST_RUN       = 2'd3
  } gb_state_t;

endpackage

// File: rtl/jesd204_tx_gearbox_ctrl_if.sv
// Control/status bundle between the link layer and the gearbox release controller.
interface jesd204_tx_gearbox_ctrl_if #(
  parameter int unsigned BEATS_W = 8,
  parameter int unsigned WAIT_W  = 4
);
  logic               enable;
  logic               lmfc_edge;
  logic [BEATS_W-1:0] cfg_beats_per_multiframe;
  logic [WAIT_W-1:0]  cfg_lmfc_wait;
  logic [BEATS_W-1:0] cfg_release_delay;
  logic               cfg_auto_resync;
  logic               status_misalign_clr;
  logic               output_ready;
  logic [1:0]         status_state;
  logic               status_misalign;
  logic [BEATS_W-1:0] lmfc_beat;

  modport master (
    output enable, lmfc_edge, cfg_beats_per_multiframe, cfg_lmfc_wait,
           cfg_release_delay, cfg_auto_resync, status_misalign_clr,
    input  output_ready, status_state, status_misalign, lmfc_beat
  );

  modport slave (
    input  enable, lmfc_edge, cfg_beats_per_multiframe, cfg_lmfc_wait,
           cfg_release_delay, cfg_auto_resync, status_misalign_clr,
    output output_ready, status_state, status_misalign, lmfc_beat
  );
endinterface

// File: rtl/jesd204_tx_gearbox_ctrl_phase_tracker.sv
// LMFC phase counter with alignment supervision; shared with the RX side.
module jesd204_lmfc_phase_tracker #(
  parameter int unsigned BEATS_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               track_en,
  input  logic               check_en,
  input  logic               lmfc_edge,
  input  logic [BEATS_W-1:0] cfg_beats_per_multiframe,
  output logic [BEATS_W-1:0] lmfc_beat,
  output logic               misalign
);
  logic edge_seen;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lmfc_beat <= '0;
      edge_seen <= 1'b0;
    end else begin
      if (lmfc_edge)
        lmfc_beat <= (cfg_beats_per_multiframe == '0) ? '0 : BEATS_W'(1);
      else if (lmfc_beat == cfg_beats_per_multiframe)
        lmfc_beat <= '0;
      else
        lmfc_beat <= lmfc_beat + 1'b1;

      // edge_seen re-qualifies on every exit from IDLE
      if (!track_en)
        edge_seen <= 1'b0;
      else if (lmfc_edge)
        edge_seen <= 1'b1;
    end
  end

  always_comb begin
    misalign = 1'b0;
    if (check_en)
      misalign = (lmfc_edge && (lmfc_beat != '0)) ||
                 ((lmfc_beat == '0) && edge_seen && !lmfc_edge);
  end
endmodule

// File: rtl/jesd204_tx_gearbox_ctrl.sv
// TX gearbox release controller: arms on a chosen LMFC edge, delays, then enables reads.
module jesd204_tx_gearbox_ctrl
  import jesd204_tx_gearbox_ctrl_pkg::*;
#(
  parameter int unsigned BEATS_W = 8,
  parameter int unsigned WAIT_W  = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  jesd204_tx_gearbox_ctrl_if.slave bus
);
  gb_state_t          state, state_next;
  logic [WAIT_W-1:0]  edge_cnt, edge_cnt_next;
  logic [BEATS_W-1:0] delay_cnt, delay_cnt_next;
  logic [BEATS_W-1:0] beat;
  logic               misalign;
  logic               output_ready_q;
  logic               misalign_q;

  jesd204_lmfc_phase_tracker #(.BEATS_W(BEATS_W)) u_phase (
    .clk                      (clk),
    .resetn                   (resetn),
    .track_en                 (state != ST_IDLE),
    .check_en                 (state == ST_RUN),
    .lmfc_edge                (bus.lmfc_edge),
    .cfg_beats_per_multiframe (bus.cfg_beats_per_multiframe),
    .lmfc_beat                (beat),
    .misalign                 (misalign)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= ST_IDLE;
      edge_cnt       <= '0;
      delay_cnt      <= '0;
      output_ready_q <= 1'b0;
      misalign_q     <= 1'b0;
    end else begin
      state          <= state_next;
      edge_cnt       <= edge_cnt_next;
      delay_cnt      <= delay_cnt_next;
      // registered copy of the next state keeps output_ready glitch-free and aligned with RUN
      output_ready_q <= (state_next == ST_RUN);
      if (misalign)
        misalign_q <= 1'b1;
      else if (bus.status_misalign_clr)
        misalign_q <= 1'b0;
    end
  end

  always_comb begin
    state_next     = state;
    edge_cnt_next  = edge_cnt;
    delay_cnt_next = delay_cnt;
    if (!bus.enable) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_next    = ST_WAIT_LMFC;
          edge_cnt_next = bus.cfg_lmfc_wait;
        end
        ST_WAIT_LMFC: begin
          if (bus.lmfc_edge) begin
            if (edge_cnt == '0) begin
              state_next     = ST_DELAY;
              delay_cnt_next = bus.cfg_release_delay;
            end else begin
              edge_cnt_next = edge_cnt - 1'b1;
            end
          end
        end
        ST_DELAY: begin
          if (delay_cnt == '0)
            state_next = ST_RUN;
          else
            delay_cnt_next = delay_cnt - 1'b1;
        end
        ST_RUN: begin
          if (misalign && bus.cfg_auto_resync) begin
            state_next    = ST_WAIT_LMFC;
            edge_cnt_next = bus.cfg_lmfc_wait;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.output_ready    = output_ready_q;
    bus.status_state    = state;
    bus.status_misalign = misalign_q;
    bus.lmfc_beat       = beat;
  end
endmodule
